down_timer: RTL and testbench

- Loadable down-counting interval timer; the count-down counterpart to the design's up-counters.
- Loads a terminal value, decrements on qualified ticks, and emits a one-cycle pulse on expiry.
- Supports one-shot and periodic (auto-reload) modes, retrigger, and abort.
- Used for exposure/strobe timing and frame-interval generation in the capture pipeline.

---
 rtl/down_timer_pkg.sv | 14 +
 rtl/down_count_core.sv | 30 +++
 rtl/down_timer.sv | 81 ++++++++
 tb/tb_down_timer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down-counting interval timer.
package down_timer_pkg;

  localparam int unsigned NBITS_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_count_core.sv
// Count register with clear/load/decrement/hold; never decrements below zero.
module down_count_core #(
  parameter int unsigned NBITS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [NBITS-1:0] load_val,
  output logic [NBITS-1:0] count,
  output logic             is_zero_c
);

  assign is_zero_c = (count == '0);

  // Priority: clear > load > decrement > hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !is_zero_c) begin
      count <= count - NBITS'(1);
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down timer: one-shot or auto-reload, with retrigger, abort,
// a one-cycle expiry pulse and a sticky overrun flag.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             enable,
  input  logic [NBITS-1:0] din,
  output logic             busy,
  output logic             expire_pulse,
  output logic [NBITS-1:0] dout,
  output logic             overrun
);

  state_t           state;
  logic [NBITS-1:0] reload;
  logic             mode;

  logic             is_zero_c;
  logic             running_c;
  logic             terminal_c;
  logic             core_load_c;
  logic             core_dec_c;
  logic [NBITS-1:0] core_val_c;

  // Terminal check is taken on the current count before any decrement.
  assign running_c   = (state == ST_RUN);
  assign terminal_c  = running_c && enable && is_zero_c;
  assign core_load_c = !stop && (start || (terminal_c && (mode == MODE_PERIODIC)));
  assign core_dec_c  = !stop && !start && running_c && enable;
  assign core_val_c  = start ? din : reload;

  down_count_core #(
    .NBITS (NBITS)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .clear     (stop),
    .load      (core_load_c),
    .dec       (core_dec_c),
    .load_val  (core_val_c),
    .count     (dout),
    .is_zero_c (is_zero_c)
  );

  assign busy = running_c;

  // Control FSM plus reload/mode latches, pulse and overrun flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      reload       <= '0;
      mode         <= MODE_ONESHOT;
      expire_pulse <= 1'b0;
      overrun      <= 1'b0;
    end else if (stop) begin
      state        <= ST_IDLE;
      expire_pulse <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      expire_pulse <= terminal_c;
      if (start) begin
        state  <= ST_RUN;
        reload <= din;
        mode   <= periodic;
        if (terminal_c) begin
          overrun <= 1'b1;
        end
      end else if (terminal_c && (mode == MODE_ONESHOT)) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed and randomized checks of down_timer against a rule-level model.
module tb_down_timer;

  localparam int unsigned NBITS = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             periodic;
  logic             enable;
  logic [NBITS-1:0] din;
  logic             busy;
  logic             expire_pulse;
  logic [NBITS-1:0] dout;
  logic             overrun;

  int errors = 0;
  int checks = 0;

  // Model state: remaining ticks before terminal, interval, mode, flags.
  bit m_run;
  int m_cnt;
  int m_rel;
  bit m_per;
  bit m_pulse;
  bit m_ovr;

  down_timer #(.NBITS(NBITS)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .periodic     (periodic),
    .enable       (enable),
    .din          (din),
    .busy         (busy),
    .expire_pulse (expire_pulse),
    .dout         (dout),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_rel = 0; m_per = 0; m_pulse = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit s, input bit sp, input bit p, input bit e, input int d);
    bit term;
    if (sp) begin
      m_run = 0; m_cnt = 0; m_ovr = 0; m_pulse = 0;
    end else begin
      term    = m_run && e && (m_cnt == 0);
      m_pulse = term;
      if (s) begin
        m_run = 1; m_cnt = d; m_rel = d; m_per = p;
        if (term) m_ovr = 1;
      end else if (term) begin
        if (m_per) m_cnt = m_rel;
        else       m_run = 0;
      end else if (m_run && e) begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NBITS-1:0] exp_dout;
    exp_dout = NBITS'(m_cnt);
    check_bit({tag, ".busy"}, busy, m_run);
    check_bit({tag, ".pulse"}, expire_pulse, m_pulse);
    check_bit({tag, ".overrun"}, overrun, m_ovr);
    checks++;
    assert (dout === exp_dout) else begin
      errors++;
      $error("FAIL %s.dout: observed=%0d expected=%0d t=%0t", tag, dout, exp_dout, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then check.
  task automatic step(input bit s, input bit sp, input bit p, input bit e,
                      input int d, input string tag);
    start = s; stop = sp; periodic = p; enable = e; din = NBITS'(d);
    @(posedge clock);
    model_step(s, sp, p, e, d);
    #1;
    check_outputs(tag);
    start = 1'b0; stop = 1'b0;
  endtask

  int pulses;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; enable = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // One-shot, din=3, enable held high.
    step(1, 0, 0, 1, 3, "os3_load");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, "os3_run");
    check_bit("os3_idle_after", busy, 1'b0);

    // Periodic din=2: four pulses in twelve cycles after load.
    step(1, 0, 1, 1, 2, "per2_load");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 0, "per2_run");
      if (expire_pulse === 1'b1) pulses++;
    end
    checks++;
    assert (pulses == 4) else begin
      errors++;
      $error("FAIL per2_pulse_count: observed=%0d expected=4", pulses);
    end
    step(0, 1, 0, 1, 0, "per2_stop");

    // Periodic din=0 with enable high, then enable toggling.
    step(1, 0, 1, 1, 0, "per0_load");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, "per0_run");
    for (int i = 0; i < 8; i++) step(0, 0, 0, i[0], 0, "per0_toggle");
    step(0, 1, 0, 0, 0, "per0_stop");

    // One-shot din=5 with enable alternating.
    step(1, 0, 0, 0, 5, "os5_load");
    for (int i = 0; i < 14; i++) step(0, 0, 0, ~i[0], 0, "os5_run");

    // Retrigger at count 2, then abort on the terminal tick.
    step(1, 0, 0, 1, 4, "rt_load");
    step(0, 0, 0, 1, 0, "rt_run");
    step(0, 0, 0, 1, 0, "rt_run");
    step(1, 0, 0, 1, 7, "rt_retrig");
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, "rt_run2");
    step(0, 1, 0, 1, 0, "rt_stop_terminal");
    step(0, 0, 0, 1, 0, "rt_after_stop");

    // Start on a periodic terminal tick: overrun and new period.
    step(1, 0, 1, 1, 3, "ovr_load");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "ovr_run");
    step(1, 0, 1, 1, 1, "ovr_start_terminal");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, "ovr_newperiod");

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_outputs("async_reset_held");

    // Randomized traffic, including boundary intervals.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
           $urandom_range(0, 1) == 1, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 15 : 0)
                                       : int'($urandom_range(0, 15)),
           "rand");
    end
    step(0, 1, 0, 0, 0, "final_stop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
